// File: rtl/regfile_banked_pkg.sv
// Shared constants for the banked register file: default geometry and the
// address of the hardwired-zero entry.
package regfile_banked_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  // Number of byte lanes in an entry of the given width.
  function automatic int num_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/regfile_banked_entry.sv
// One register-file entry: async-reset storage with byte-enabled write on
// either the rising or the falling clock edge.
module regfile_banked_entry
  import regfile_banked_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WR_NEG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  output logic [DATA_W-1:0]   q
);

  localparam int NB = num_bytes(DATA_W);

  generate
    if (WR_NEG != 0) begin : g_neg
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (we) begin
          for (int i = 0; i < NB; i++) begin
            if (wbe[i]) q[8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
    end else begin : g_pos
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (we) begin
          for (int i = 0; i < NB; i++) begin
            if (wbe[i]) q[8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/regfile_banked.sv
// Parametrised CPU register file: one byte-enabled write port, NUM_RD
// combinational read ports, optional write-to-read bypass and zero entry.
module regfile_banked
  import regfile_banked_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int WR_NEG  = 1,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wbe,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  localparam int  DEPTH   = 2**ADDR_W;
  localparam int  NB      = num_bytes(DATA_W);
  localparam bit  USE_BYP = (BYPASS != 0) && (WR_NEG == 0);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DATA_W-1:0]            wmask;

  generate
    for (genvar b = 0; b < NB; b++) begin : g_mask
      assign wmask[8*b +: 8] = {8{wbe[b]}};
    end

    for (genvar a = 0; a < DEPTH; a++) begin : g_entry
      if ((ZERO_R0 != 0) && (a == REG_ZERO)) begin : g_zero
        assign mem[a] = '0;
      end else begin : g_reg
        logic we_a;
        assign we_a = wen && (waddr == ADDR_W'(a));
        regfile_banked_entry #(
          .DATA_W (DATA_W),
          .WR_NEG (WR_NEG)
        ) u_entry (
          .clk   (clk),
          .rst   (rst),
          .we    (we_a),
          .wdata (wdata),
          .wbe   (wbe),
          .q     (mem[a])
        );
      end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] ent;
      logic              hit;
      logic              is_zero;

      assign ra      = raddr[p*ADDR_W +: ADDR_W];
      assign ent     = mem[ra];
      // Bypass is held off during reset so every port reads 0 while rst is high.
      assign hit     = USE_BYP && wen && !rst && (ra == waddr);
      assign is_zero = (ZERO_R0 != 0) && (ra == ADDR_W'(REG_ZERO));

      assign rdata[p*DATA_W +: DATA_W] =
        is_zero ? '0 :
        hit     ? ((wdata & wmask) | (ent & ~wmask)) :
                  ent;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_banked.sv
// Directed bench for regfile_banked: three instances (negedge write, posedge
// with bypass and 4 read ports, posedge without bypass) share the write port.
`timescale 1ns/1ps
module tb_regfile_banked;

  logic        clk;
  logic        clk_run;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [9:0]  raddr_a;
  logic [63:0] rdata_a;
  logic [19:0] raddr_b;
  logic [127:0] rdata_b;
  logic [9:0]  raddr_c;
  logic [63:0] rdata_c;

  int n_cmp;
  int n_err;

  // a: legacy negedge write, zero entry
  regfile_banked #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .WR_NEG(1), .BYPASS(1), .ZERO_R0(1)) dut_a (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr(raddr_a), .rdata(rdata_a)
  );
  // b: posedge write with bypass, no zero entry, four read ports
  regfile_banked #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .WR_NEG(0), .BYPASS(1), .ZERO_R0(0)) dut_b (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr(raddr_b), .rdata(rdata_b)
  );
  // c: posedge write without bypass, zero entry
  regfile_banked #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .WR_NEG(0), .BYPASS(0), .ZERO_R0(1)) dut_c (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr(raddr_c), .rdata(rdata_c)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_rd(input logic [4:0] addr);
    raddr_a = {2{addr}};
    raddr_b = {4{addr}};
    raddr_c = {2{addr}};
  endtask

  task automatic drive_wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(posedge clk); #1;
    wen = 1'b1; waddr = addr; wdata = data; wbe = be;
  endtask

  task automatic end_wr();
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
    drive_wr(addr, data, be);
    end_wr();
  endtask

  // Same expected value on every port of every instance.
  task automatic check_all(input string tag, input logic [31:0] exp);
    check({tag, "_a0"}, rdata_a[31:0],  exp);
    check({tag, "_a1"}, rdata_a[63:32], exp);
    for (int p = 0; p < 4; p++) check($sformatf("%s_b%0d", tag, p), rdata_b[p*32 +: 32], exp);
    check({tag, "_c0"}, rdata_c[31:0],  exp);
    check({tag, "_c1"}, rdata_c[63:32], exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_cmp = 0; n_err = 0;
    clk_run = 1'b1;
    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; wbe = '0;
    set_rd(5'd7);
    #12;
    check_all("reset_state", 32'h0);
    rst = 1'b0;

    // Reset with clock stopped
    do_write(5'd7, 32'hDEADBEEF, 4'hF);
    check_all("preload7", 32'hDEADBEEF);
    @(negedge clk); #1;
    clk_run = 1'b0;
    #2; rst = 1'b1;
    #1; check_all("async_rst", 32'h0);
    #2; rst = 1'b0;
    #1; check_all("after_rst_noclk", 32'h0);
    clk_run = 1'b1;
    do_write(5'd7, 32'h12345678, 4'hF);
    check_all("post_rst_wr", 32'h12345678);

    // Byte enables
    set_rd(5'd3);
    do_write(5'd3, 32'h11223344, 4'b1111);
    check_all("be_full", 32'h11223344);
    do_write(5'd3, 32'hAABBCCDD, 4'b0101);
    check_all("be_0101", 32'h11BB33DD);
    do_write(5'd3, 32'hFFFFFFFF, 4'b0000);
    check_all("be_none", 32'h11BB33DD);

    // Zero entry
    set_rd(5'd0);
    do_write(5'd0, 32'hFFFFFFFF, 4'hF);
    check("zero_a0", rdata_a[31:0],  32'h0);
    check("zero_a1", rdata_a[63:32], 32'h0);
    check("zero_c0", rdata_c[31:0],  32'h0);
    check("zero_c1", rdata_c[63:32], 32'h0);
    for (int p = 0; p < 4; p++) check($sformatf("nozero_b%0d", p), rdata_b[p*32 +: 32], 32'hFFFFFFFF);

    // Write timing within one cycle
    set_rd(5'd9);
    do_write(5'd9, 32'h0000000A, 4'hF);
    drive_wr(5'd9, 32'h00000005, 4'hF);
    #1;
    check("neg_before_fall_a0", rdata_a[31:0], 32'hA);
    check("byp_same_cycle_b0", rdata_b[31:0], 32'h5);
    check("nobyp_before_c0", rdata_c[31:0], 32'hA);
    @(negedge clk); #1;
    check("neg_after_fall_a0", rdata_a[31:0], 32'h5);
    check("nobyp_after_fall_c0", rdata_c[31:0], 32'hA);
    end_wr();
    check("nobyp_after_rise_c0", rdata_c[31:0], 32'h5);

    // Bypass merge with partial byte enables; addr 4 never written
    raddr_b[9:5] = 5'd4;
    raddr_c[9:5] = 5'd4;
    drive_wr(5'd4, 32'hCAFEF00D, 4'b1100);
    #1;
    check("byp_merge_b1", rdata_b[63:32], 32'hCAFE0000);
    check("nobyp_old_c1", rdata_c[63:32], 32'h0);
    check("byp_other_port_b0", rdata_b[31:0], 32'h5);
    end_wr();
    check("byp_commit_b1", rdata_b[63:32], 32'hCAFE0000);
    check("nobyp_commit_c1", rdata_c[63:32], 32'hCAFE0000);

    // Multi-port read of 12 while writing 13
    do_write(5'd12, 32'h0C0C5A5A, 4'hF);
    set_rd(5'd12);
    drive_wr(5'd13, 32'h13131313, 4'hF);
    #1;
    for (int p = 0; p < 4; p++) check($sformatf("mp_during_b%0d", p), rdata_b[p*32 +: 32], 32'h0C0C5A5A);
    end_wr();
    for (int p = 0; p < 4; p++) check($sformatf("mp_after_b%0d", p), rdata_b[p*32 +: 32], 32'h0C0C5A5A);
    raddr_b[19:15] = 5'd13;
    #1;
    check("mp_addr13_b3", rdata_b[127:96], 32'h13131313);
    check("mp_addr12_b2", rdata_b[95:64],  32'h0C0C5A5A);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
